two_five_rx: RTL

TWO_FIVE_RX -- requirements
Module: two_five_rx

---
 rtl/two_five_rx.sv | 137 +++++++++++++
 1 files changed

// File: rtl/two_five_rx.sv
// Serial 2-of-5 code receiver: shifts in five code bits, decodes to a digit,
// and holds the result in a one-entry ready/valid output buffer.
module two_five_rx #(
   parameter int unsigned ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sin,
   input  logic             sin_vld,
   input  logic             sync,
   output logic [3:0]       dout,
   output logic             dout_err,
   output logic             dout_vld,
   input  logic             dout_rdy,
   output logic             ovf,
   input  logic             clr,
   output logic [ERR_W-1:0] err_cnt
);

   localparam int unsigned SYM_W    = 5;
   localparam int unsigned CNT_W    = 3;
   localparam int unsigned DIG_W    = 4;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SYM_W - 1);
   localparam logic [DIG_W-1:0] BAD_DIG  = DIG_W'(4'hF);

   logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
   logic [SYM_W-1:0] shreg_q, shreg_d;
   logic [DIG_W-1:0] dout_q, dout_d;
   logic             dout_err_q, dout_err_d;
   logic             dout_vld_q, dout_vld_d;
   logic             ovf_q, ovf_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

   logic             accept_c;
   logic             done_c;
   logic [SYM_W-1:0] code_c;
   logic [DIG_W-1:0] sym_c;
   logic             sym_err_c;
   logic             load_c;
   logic             drop_c;

   // Weights 7,4,2,1,0; every two-hot code maps to a digit, anything else is invalid.
   function automatic logic [DIG_W-1:0] decode(input logic [SYM_W-1:0] c);
      logic [DIG_W-1:0] d;
      case (c)
         5'b11000: d = DIG_W'(0);
         5'b00011: d = DIG_W'(1);
         5'b00101: d = DIG_W'(2);
         5'b00110: d = DIG_W'(3);
         5'b01001: d = DIG_W'(4);
         5'b01010: d = DIG_W'(5);
         5'b01100: d = DIG_W'(6);
         5'b10001: d = DIG_W'(7);
         5'b10010: d = DIG_W'(8);
         5'b10100: d = DIG_W'(9);
         default:  d = BAD_DIG;
      endcase
      return d;
   endfunction

   // Symbol completion and buffer arbitration.
   always_comb begin
      accept_c  = sin_vld & ~sync;
      code_c    = {shreg_q[SYM_W-2:0], sin};
      done_c    = accept_c && (bitcnt_q == LAST_BIT);
      sym_c     = decode(code_c);
      sym_err_c = (sym_c == BAD_DIG);
      load_c    = done_c && (!dout_vld_q || dout_rdy);
      drop_c    = done_c && dout_vld_q && !dout_rdy;
   end

   // Next-state logic.
   always_comb begin
      bitcnt_d   = bitcnt_q;
      shreg_d    = shreg_q;
      dout_d     = dout_q;
      dout_err_d = dout_err_q;
      dout_vld_d = dout_vld_q;
      ovf_d      = ovf_q;
      err_cnt_d  = err_cnt_q;

      if (sync) begin
         bitcnt_d = '0;
      end else if (sin_vld) begin
         shreg_d  = code_c;
         bitcnt_d = (bitcnt_q == LAST_BIT) ? '0 : bitcnt_q + CNT_W'(1);
      end

      if (load_c) begin
         dout_d     = sym_c;
         dout_err_d = sym_err_c;
         dout_vld_d = 1'b1;
      end else if (dout_vld_q && dout_rdy) begin
         dout_vld_d = 1'b0;
      end

      // clr wins over a same-edge drop or error increment.
      if (clr) begin
         ovf_d     = 1'b0;
         err_cnt_d = '0;
      end else begin
         if (drop_c) begin
            ovf_d = 1'b1;
         end
         if (done_c && sym_err_c && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bitcnt_q   <= '0;
         shreg_q    <= '0;
         dout_q     <= '0;
         dout_err_q <= 1'b0;
         dout_vld_q <= 1'b0;
         ovf_q      <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         bitcnt_q   <= bitcnt_d;
         shreg_q    <= shreg_d;
         dout_q     <= dout_d;
         dout_err_q <= dout_err_d;
         dout_vld_q <= dout_vld_d;
         ovf_q      <= ovf_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign dout     = dout_q;
   assign dout_err = dout_err_q;
   assign dout_vld = dout_vld_q;
   assign ovf      = ovf_q;
   assign err_cnt  = err_cnt_q;

endmodule
